// File: rtl/execute_stage_mx.sv
// Execute stage of the 5-stage RV32 pipeline: forwarding, ALU, branch/jump redirect,
// an optional shift-add multiplier that stalls upstream via BusyE, and the E/M register.
module execute_stage_mx #(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ValidE,
    input  logic            FlushE,
    input  logic            regwriteE,
    input  logic            MemWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic [2:0]      funct3E,
    input  logic [3:0]      ALUControlE,
    input  logic            ALUSrcE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_ExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] ResultW,
    input  logic [4:0]      RD_E,
    output logic            PCsrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            BusyE,
    output logic            regwriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] ALU_ResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [3:0] OP_MUL = 4'b1100;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} mul_state_e;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] mul_result;
    logic [XLEN-1:0] em_result;
    logic [SHW-1:0]  shamt;
    logic            taken;
    logic            busy;
    logic            mul_done;
    logic            em_bubble;

    // Code 11 is reserved and falls back to the register-file value.
    always_comb begin
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALU_ResultM;
            default: src_a = RD1_E;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALU_ResultM;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_ExtE : fwd_b;
    assign shamt = src_b[SHW-1:0];

    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            4'b0000: alu_result = src_a + src_b;
            4'b0001: alu_result = src_a - src_b;
            4'b0010: alu_result = src_a & src_b;
            4'b0011: alu_result = src_a | src_b;
            4'b0111: alu_result = src_a ^ src_b;
            4'b0101: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b0110: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            4'b1000: alu_result = src_a << shamt;
            4'b1001: alu_result = src_a >> shamt;
            4'b1010: alu_result = $unsigned($signed(src_a) >>> shamt);
            default: alu_result = '0;
        endcase
    end

    // Branches compare against the forwarded rs2, never the immediate.
    always_comb begin
        taken = 1'b0;
        case (funct3E)
            3'b000:  taken = (src_a == fwd_b);
            3'b001:  taken = (src_a != fwd_b);
            3'b100:  taken = ($signed(src_a) < $signed(fwd_b));
            3'b101:  taken = ($signed(src_a) >= $signed(fwd_b));
            3'b110:  taken = (src_a < fwd_b);
            3'b111:  taken = (src_a >= fwd_b);
            default: taken = 1'b0;
        endcase
    end

    assign PCsrcE    = ValidE & ~FlushE & (JumpE | JalrE | (BranchE & taken));
    assign PCTargetE = JalrE ? ((src_a + Imm_ExtE) & {{(XLEN-1){1'b1}}, 1'b0})
                             : (PCE + Imm_ExtE);

    generate
        if (MUL_EN) begin : g_mul
            mul_state_e      state_q, state_d;
            logic [XLEN-1:0] mcand_q, mplier_q, acc_q;
            logic [SHW-1:0]  cnt_q;
            logic            issue;

            assign issue = ValidE & ~FlushE & (ALUControlE == OP_MUL);

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= S_IDLE;
                end else begin
                    state_q <= state_d;
                end
            end

            always_comb begin
                state_d = state_q;
                case (state_q)
                    S_IDLE:  if (issue) state_d = S_MUL;
                    S_MUL: begin
                        if (FlushE)                              state_d = S_IDLE;
                        else if (cnt_q == SHW'(XLEN-1))          state_d = S_DONE;
                    end
                    S_DONE:  state_d = S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end

            // Busy covers the issue cycle so upstream freezes before operands are lost.
            always_comb begin
                busy     = (state_q == S_MUL) | ((state_q == S_IDLE) & issue);
                mul_done = (state_q == S_DONE);
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    mcand_q  <= '0;
                    mplier_q <= '0;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                end else if ((state_q == S_IDLE) && issue) begin
                    mcand_q  <= src_a;
                    mplier_q <= src_b;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                end else if (state_q == S_MUL) begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                end
            end

            assign mul_result = acc_q;
        end else begin : g_no_mul
            assign busy       = 1'b0;
            assign mul_done   = 1'b0;
            assign mul_result = '0;
        end
    endgenerate

    assign BusyE     = busy;
    assign em_result = mul_done ? mul_result : alu_result;
    assign em_bubble = reset | FlushE | ~ValidE | busy;

    always_ff @(posedge clk) begin
        if (em_bubble) begin
            regwriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 2'b00;
            RD_M        <= '0;
            ALU_ResultM <= '0;
            WriteDataM  <= '0;
            PCPlus4M    <= '0;
        end else begin
            regwriteM   <= regwriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            ALU_ResultM <= em_result;
            WriteDataM  <= fwd_b;
            PCPlus4M    <= PCPlus4E;
        end
    end

endmodule

// File: doc/execute_stage_mx.md
# execute_stage_mx

Parametrised execute stage with E/M pipeline register for the 5-stage RISC-V core. It replaces the fixed 32-bit execute cycle and adds:
- operand forwarding muxes;
- the full RV32I branch condition set plus JAL/JALR target generation;
- flush/bubble control;
- an optional iterative multiplier that stalls upstream stages through a busy handshake.

It sits between the decode and memory stages, fed by the D/E register and the hazard unit.

## Interface
Parameters:
- XLEN, 32, datapath width (≥8)
- MUL_EN, 1, 1 = include iterative multiplier; 0 = no multiplier, op 1100 yields 0

Ports (clock and reset first; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- ValidE  in  1  instruction in E is real (not a bubble)
- FlushE  in  1  kill instruction in E; load bubble into E/M
- regwriteE, MemWriteE  in  1 each  control pass-through
- ResultSrcE  in  2  00 ALU, 01 memory, 10 PC+4
- BranchE, JumpE, JalrE  in  1 each  conditional branch / JAL / JALR
- funct3E  in  3  branch condition
- ALUControlE  in  4  ALU operation
- ALUSrcE  in  1  0 = SrcB from register, 1 = immediate
- ForwardAE, ForwardBE  in  2  00 RD1/RD2, 01 ResultW, 10 ALU_ResultM, 11 reserved (treated as 00)
- RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E, ResultW  in  XLEN  operands
- RD_E  in  5  destination register
- PCsrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  XLEN  redirect target (combinational)
- BusyE  out  1  multiply in progress; upstream must hold the D/E register and fetch
- regwriteM, MemWriteM  out  1 each  registered control
- ResultSrcM  out  2  registered
- RD_M  out  5  registered
- ALU_ResultM, WriteDataM, PCPlus4M  out  XLEN  registered

## Operation
Operand selection:
- SrcAE = forward mux A.
- FwdB = forward mux B.
- SrcBE = ALUSrcE ? Imm_ExtE : FwdB.
- WriteDataM captures FwdB.

ALU ops, all modulo 2^XLEN:
- 0000 add, 0001 sub, 0010 and, 0011 or, 0111 xor
- 0101 slt (signed), 0110 sltu: result 1 or 0, zero-extended
- 1000 sll, 1001 srl, 1010 sra: shift amount SrcBE[log2(XLEN)-1:0]
- 1100 mul: low XLEN bits of product
- any other code: result 0

Branch conditions (funct3E), evaluated on SrcAE vs FwdB:
- 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu
- 010 and 011: never taken

Redirect:
- PCsrcE = ValidE & ~FlushE & (JumpE | JalrE | (BranchE & taken)).
- PCTargetE = JalrE ? ((SrcAE + Imm_ExtE) & ~1) : (PCE + Imm_ExtE).

Multiplier FSM (MUL_EN = 1), states IDLE, MUL, DONE:
- IDLE, on ValidE & ~FlushE & op 1100:
  - latch mcand = SrcAE, mplier = SrcBE; clear acc and cnt
  - assert BusyE; go to MUL
- MUL, each cycle:
  - if mplier[0], acc += mcand
  - mcand <<= 1, mplier >>= 1, cnt++
  - BusyE = 1
  - when cnt == XLEN-1, go to DONE
- DONE: BusyE = 0; the E/M register loads acc with the held control; go to IDLE.
- Operands are captured at issue, so forwarded values need not stay valid while busy.
- MUL_EN = 0: BusyE is tied to 0.

E/M register load rules, by priority:
1. reset: all outputs 0.
2. FlushE, ~ValidE, or BusyE = 1: bubble. regwriteM = 0, MemWriteM = 0, ResultSrcM = 00, RD_M = 0, data fields = 0.
3. Otherwise: load control, RD_E, PCPlus4E, WriteData, and the ALU or multiplier result.

Boundary behaviour:
- FlushE during MUL or DONE: FSM returns to IDLE; BusyE = 0 from the next cycle; no result is written.
- reset mid-multiply: IDLE; BusyE = 0 after the edge.
- ALUControlE = 1100 together with a branch: undefined; the decoder never issues it.

## Timing
- Single-cycle ops: result appears on ALU_ResultM one edge after the E cycle.
- Multiply: BusyE is high for XLEN+1 consecutive cycles, counting the issue cycle (33 at XLEN = 32).
- The result is registered at the end of the DONE cycle: XLEN+2 cycles in E in total.
- Upstream holds the E inputs constant while BusyE = 1.
- PCsrcE, PCTargetE and BusyE are combinational from current inputs and state.
- No combinational path from ResultW or ALU_ResultM to the E/M outputs exists except through the forward muxes.

## Test plan
- Forwarding: RD1_E = 5, ALU_ResultM = 7, ForwardAE = 10, RD2_E = 3, add → ALU_ResultM = 10 next cycle.
- Branch set: SrcA = 0xFFFFFFFF, FwdB = 1.
  - blt taken; bltu not taken; bne taken.
  - PCE = 0x100, Imm = 0x20 → PCTargetE = 0x120.
- JALR: SrcA = 0x1003, Imm = 4 → PCsrcE = 1, PCTargetE = 0x1006; PCPlus4M = PCPlus4E and ResultSrcM = 10 next cycle.
- Multiply, XLEN = 32: 0xFFFFFFFF × 3.
  - BusyE high 33 cycles with bubbles in M (regwriteM = 0).
  - Then ALU_ResultM = 0xFFFFFFFD and regwriteM = 1.
- Flush mid-multiply: FlushE asserted at cycle 10 of the multiply → BusyE = 0 next cycle; regwriteM stays 0; the next add completes normally.
- Reset: assert reset mid-multiply with outputs non-zero → every output 0 and BusyE = 0 after one edge; MUL_EN = 0 build returns 0 for op 1100 with no stall.
